// File: rtl/axi_lite_sram_slave.sv
// AXI-lite single-port word SRAM responder with configurable read/write latency, one transaction at a time.
// Optional AXI_SRAM_RAND_DELAY_EN adds 0..3 cycles of LFSR-driven jitter to each access latency.
module axi_lite_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WR_LATENCY  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] araddr_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  input  logic [31:0] awaddr_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef AXI_SRAM_RAND_DELAY_EN
  localparam int unsigned JITTER_MAX = 3;
`else
  localparam int unsigned JITTER_MAX = 0;
`endif
  localparam int unsigned MAX_LAT = ((RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY) + JITTER_MAX;
  localparam int unsigned CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_W_NEED_W, S_W_NEED_AW, S_RD_WAIT, S_WR_WAIT, S_R_RESP, S_B_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             rvalid_q, rvalid_d;
  logic             bvalid_q, bvalid_d;
  logic             mem_we_c;
  logic [CNT_W-1:0] rd_lat_c, wr_lat_c;

  logic [31:0] mem [DEPTH_WORDS];

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4, free-running
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign rd_lat_c = CNT_W'(RD_LATENCY + 32'(lfsr_q[1:0]));
  assign wr_lat_c = CNT_W'(WR_LATENCY + 32'(lfsr_q[1:0]));
`else
  assign rd_lat_c = CNT_W'(RD_LATENCY);
  assign wr_lat_c = CNT_W'(WR_LATENCY);
`endif

  // Address decode of the captured address; the byte offset bits are don't-care
  logic [31:0]      off_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic             unused_c;

  assign off_c      = addr_q - ADDR_BASE;
  assign in_range_c = (addr_q >= ADDR_BASE) && (off_c[31:2] < 30'(DEPTH_WORDS));
  assign idx_c      = off_c[IDX_W+1:2];
  assign unused_c   = ^off_c[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    bvalid_d  = bvalid_q;
    mem_we_c  = 1'b0;
    arready_o = 1'b0;
    awready_o = 1'b0;
    wready_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        awready_o = 1'b1;
        wready_o  = 1'b1;
        arready_o = ~awvalid_i & ~wvalid_i;
        if (awvalid_i) addr_d = awaddr_i;
        if (wvalid_i) begin
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
        end
        if (awvalid_i && wvalid_i) begin
          state_d = S_WR_WAIT;
          cnt_d   = wr_lat_c;
        end else if (awvalid_i) begin
          state_d = S_W_NEED_W;
        end else if (wvalid_i) begin
          state_d = S_W_NEED_AW;
        end else if (arvalid_i) begin
          addr_d  = araddr_i;
          state_d = S_RD_WAIT;
          cnt_d   = rd_lat_c;
        end
      end
      S_W_NEED_W: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
          state_d = S_WR_WAIT;
          cnt_d   = wr_lat_c;
        end
      end
      S_W_NEED_AW: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          addr_d  = awaddr_i;
          state_d = S_WR_WAIT;
          cnt_d   = wr_lat_c;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d  = in_range_c ? mem[idx_c] : 32'h0;
          rresp_d  = in_range_c ? RESP_OKAY : RESP_DECERR;
          rvalid_d = 1'b1;
          state_d  = S_R_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_WAIT: begin
        if (cnt_q == '0) begin
          mem_we_c = in_range_c;
          bresp_d  = in_range_c ? RESP_OKAY : RESP_DECERR;
          bvalid_d = 1'b1;
          state_d  = S_B_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_R_RESP: begin
        if (rready_i) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_B_RESP: begin
        if (bready_i) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      bresp_q  <= '0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
    end
  end

  // Array is not reset; byte-strobed commit
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;
  assign rvalid_o = rvalid_q;
  assign bresp_o  = bresp_q;
  assign bvalid_o = bvalid_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave with default parameters (RD/WR latency 1, 4096 words).
module tb_axi_lite_sram_slave;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] araddr_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] awaddr_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  axi_lite_sram_slave dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Expects bvalid exactly 2 cycles after the completing handshake edge
  task automatic wait_b(input string tag, input logic [1:0] exp_resp);
    int lat = 0;
    while (!bvalid_o && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, " b_latency"}, 32'(lat), 32'd2);
    chk({tag, " bresp"}, 32'(bresp_o), 32'(exp_resp));
    bready_i = 1'b1;
    step();
    bready_i = 1'b0;
    chk({tag, " bvalid_drop"}, 32'(bvalid_o), 32'd0);
  endtask

  task automatic write_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    logic aw_done = 1'b0;
    logic w_done  = 1'b0;
    logic hs_aw, hs_w;
    int   n = 0;
    awaddr_i  = addr;
    wdata_i   = data;
    wstrb_i   = strb;
    awvalid_i = 1'b1;
    wvalid_i  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      #1;
      hs_aw = awvalid_i && awready_o;
      hs_w  = wvalid_i && wready_o;
      step();
      n++;
      if (hs_aw) begin awvalid_i = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid_i  = 1'b0; w_done  = 1'b1; end
    end
    awvalid_i = 1'b0;
    wvalid_i  = 1'b0;
    chk({tag, " accept"}, 32'(aw_done && w_done), 32'd1);
    wait_b(tag, exp_resp);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int stall);
    logic done = 1'b0;
    logic hs;
    int   n = 0;
    int   lat = 0;
    araddr_i  = addr;
    arvalid_i = 1'b1;
    while (!done && n < 20) begin
      #1;
      hs = arvalid_i && arready_o;
      step();
      n++;
      if (hs) begin arvalid_i = 1'b0; done = 1'b1; end
    end
    arvalid_i = 1'b0;
    chk({tag, " ar_accept"}, 32'(done), 32'd1);
    while (!rvalid_o && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, " r_latency"}, 32'(lat), 32'd2);
    chk({tag, " rdata"}, rdata_o, exp_data);
    chk({tag, " rresp"}, 32'(rresp_o), 32'(exp_resp));
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, " stall rvalid"}, 32'(rvalid_o), 32'd1);
      chk({tag, " stall rdata"}, rdata_o, exp_data);
      chk({tag, " stall rresp"}, 32'(rresp_o), 32'(exp_resp));
    end
    rready_i = 1'b1;
    step();
    rready_i = 1'b0;
    chk({tag, " rvalid_drop"}, 32'(rvalid_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b0;
    araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
    awaddr_i = '0; awvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0;
    bready_i = 1'b0;
    step();
    step();
    chk("reset rvalid", 32'(rvalid_o), 32'd0);
    chk("reset bvalid", 32'(bvalid_o), 32'd0);
    chk("reset rdata", rdata_o, 32'h0);
    chk("reset rresp", 32'(rresp_o), 32'd0);
    chk("reset bresp", 32'(bresp_o), 32'd0);
    rst_i = 1'b1;
    step();
    chk("idle arready", 32'(arready_o), 32'd1);
    chk("idle awready", 32'(awready_o), 32'd1);
    chk("idle wready", 32'(wready_o), 32'd1);

    // Basic write then read
    write_chk("wr1", 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2'b00);
    read_chk("rd1", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);

    // Partial strobe merge; byte offset in address ignored
    write_chk("wr2a", 32'h8000_0020, 32'h1122_3344, 4'b1111, 2'b00);
    write_chk("wr2b", 32'h8000_0023, 32'hAABB_CCDD, 4'b0101, 2'b00);
    read_chk("rd2", 32'h8000_0020, 32'h11BB_33DD, 2'b00, 0);

    // Out-of-range read/write; 0x8000_4000 aliases word 0 if undecoded
    write_chk("wr3a", 32'h8000_0000, 32'h0123_4567, 4'b1111, 2'b00);
    read_chk("rd_oor", 32'h7FFF_FFFC, 32'h0, 2'b11, 0);
    write_chk("wr_oor", 32'h8000_4000, 32'hFFFF_FFFF, 4'b1111, 2'b11);
    read_chk("rd3", 32'h8000_0000, 32'h0123_4567, 2'b00, 0);
    read_chk("rd_oor_hi", 32'h8000_4000, 32'h0, 2'b11, 0);

    // Last word and zero strobe
    write_chk("wr_last", 32'h8000_3FFC, 32'hCAFE_F00D, 4'b1111, 2'b00);
    write_chk("wr_zero_strb", 32'h8000_3FFC, 32'h0000_0000, 4'b0000, 2'b00);
    read_chk("rd_last", 32'h8000_3FFC, 32'hCAFE_F00D, 2'b00, 0);

    // AR and AW/W in the same cycle: write wins
    awaddr_i = 32'h8000_0030; wdata_i = 32'h5A5A_1234; wstrb_i = 4'b1111;
    araddr_i = 32'h8000_0030;
    awvalid_i = 1'b1; wvalid_i = 1'b1; arvalid_i = 1'b1;
    #1;
    chk("coll arready", 32'(arready_o), 32'd0);
    chk("coll awready", 32'(awready_o), 32'd1);
    step();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    chk("coll busy arready", 32'(arready_o), 32'd0);
    wait_b("coll_wr", 2'b00);
    read_chk("coll_rd", 32'h8000_0030, 32'h5A5A_1234, 2'b00, 0);

    // W three cycles ahead of AW, then read with a 5-cycle rready stall
    wdata_i = 32'h0BAD_CAFE; wstrb_i = 4'b1111; wvalid_i = 1'b1;
    #1;
    chk("early_w wready", 32'(wready_o), 32'd1);
    step();
    wvalid_i = 1'b0;
    step();
    step();
    chk("need_aw awready", 32'(awready_o), 32'd1);
    chk("need_aw wready", 32'(wready_o), 32'd0);
    chk("need_aw arready", 32'(arready_o), 32'd0);
    chk("need_aw bvalid", 32'(bvalid_o), 32'd0);
    awaddr_i = 32'h8000_0040; awvalid_i = 1'b1;
    #1;
    chk("late_aw awready", 32'(awready_o), 32'd1);
    step();
    awvalid_i = 1'b0;
    wait_b("early_w", 2'b00);
    chk("early_w idle awready", 32'(awready_o), 32'd1);
    read_chk("stall_rd", 32'h8000_0040, 32'h0BAD_CAFE, 2'b00, 5);

    // Reset while a read is waiting on latency
    araddr_i = 32'h8000_0010; arvalid_i = 1'b1;
    #1;
    step();
    arvalid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("rst_mid rvalid", 32'(rvalid_o), 32'd0);
    step();
    step();
    chk("rst_hold rvalid", 32'(rvalid_o), 32'd0);
    rst_i = 1'b1;
    step();
    step();
    step();
    chk("post_rst rvalid", 32'(rvalid_o), 32'd0);
    chk("post_rst arready", 32'(arready_o), 32'd1);
    read_chk("post_rst_rd", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
    read_chk("post_rst_rd2", 32'h8000_0020, 32'h11BB_33DD, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
AXI-lite responder that is the memory end of the core's instruction and data fetch paths. It sits behind axi_lite_arbitrator and answers AR/R and AW/W/B transactions from a single-port internal word array. It models configurable access latency so that the IFU, EXU and LSU handshakes can be exercised with multi-cycle stalls. It handles one outstanding transaction at a time.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 4096, number of 32-bit words (power of two)
RD_LATENCY, 1, extra wait cycles between AR handshake and rvalid_o
WR_LATENCY, 1, extra wait cycles between last of AW/W handshake and bvalid_o

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
araddr_i  in  32  read address
arvalid_i  in  1  read address valid
arready_o  out  1  read address ready
rdata_o  out  32  read data
rresp_o  out  2  read response (00 OKAY, 11 DECERR)
rvalid_o  out  1  read data valid
rready_i  in  1  read data ready
awaddr_i  in  32  write address
awvalid_i  in  1  write address valid
awready_o  out  1  write address ready
wdata_i  in  32  write data
wstrb_i  in  4  byte strobes
wvalid_i  in  1  write data valid
wready_o  out  1  write data ready
bresp_o  out  2  write response
bvalid_o  out  1  write response valid
bready_i  in  1  write response ready

Behaviour:
- Reset (rst_i low, async): state IDLE, rvalid_o=0, bvalid_o=0, rdata_o=0, rresp_o=0, bresp_o=0, counter=0; pending transaction dropped; array contents not cleared.
- States: IDLE, W_NEED_W (AW taken), W_NEED_AW (W taken), RD_WAIT, WR_WAIT, R_RESP, B_RESP.
- IDLE: awready_o=1, wready_o=1, arready_o=~awvalid_i & ~wvalid_i (writes win a same-cycle collision).
- IDLE + AW and W both handshake -> WR_WAIT; only AW -> W_NEED_W (wready_o=1 only); only W -> W_NEED_AW (awready_o=1 only); captured address/data/strobe held in registers.
- IDLE + AR handshake -> RD_WAIT, address captured, counter loaded with RD_LATENCY.
- RD_WAIT/WR_WAIT: counter decrements each cycle; at 0 array access performed, move to R_RESP/B_RESP. rvalid_o rises exactly RD_LATENCY+1 cycles after AR handshake edge; bvalid_o rises WR_LATENCY+1 cycles after the completing write handshake. Latency 0 -> valid on next cycle.
- Write commits to array on WR_WAIT exit; bytes with wstrb_i bit 0 unchanged; wstrb 0000 commits nothing, bresp OKAY.
- R_RESP: rvalid_o, rdata_o, rresp_o stable until rready_i; on handshake rvalid_o=0, -> IDLE. B_RESP likewise with bvalid_o/bready_i.
- No readies asserted outside IDLE/W_NEED_*: at most one transaction in flight.
- Address decode: index=(addr-ADDR_BASE)>>2, addr[1:0] ignored. Out-of-range (addr<ADDR_BASE or index>=DEPTH_WORDS): read returns rdata_o=0, rresp_o=11; write discarded, bresp_o=11.
- Counter width: $clog2 of max latency +1; counter never wraps (loads, counts to 0, stops).

Optional Feature:
AXI_SRAM_RAND_DELAY_EN: 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5, advances every cycle, reset to seed); effective latency = parameter + lfsr[1:0]. Without macro: latency exactly RD_LATENCY/WR_LATENCY, no LFSR logic.

Test Plan:
- AW 0x8000_0010, W 0xDEADBEEF strb 1111 same cycle; then AR 0x8000_0010 -> bresp 00, rdata 0xDEADBEEF, rresp 00, rvalid 2 cycles after AR handshake (RD_LATENCY=1).
- Write 0x11223344 then strb 0101 data 0xAABBCCDD to same word -> readback 0x11BB33DD.
- AR 0x7FFF_FFFC and AW 0x8000_4000 (DEPTH 4096) -> rresp 11, rdata 0; bresp 11, array unchanged.
- arvalid and awvalid asserted same cycle in IDLE -> write completes first (arready_o 0 that cycle), read accepted after B handshake.
- W asserted 3 cycles before AW; rready_i held low 5 cycles on a read -> write commits once; rdata_o/rvalid_o stable through stall.
- rst_i low during RD_WAIT -> rvalid_o 0 immediately, state IDLE after release, earlier written data still readable.
